// File: rtl/motor_ctrl_pkg.sv
// motor_ctrl_pkg: shared command codes, ramp FSM states and default duty ceiling
package motor_ctrl_pkg;
  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_SET     = 3'd1;
  localparam logic [2:0] CMD_UP      = 3'd2;
  localparam logic [2:0] CMD_DOWN    = 3'd3;
  localparam logic [2:0] CMD_STOP    = 3'd4;
  localparam logic [2:0] CMD_REVERSE = 3'd5;
  localparam int MAX_RATE_DEF = 99;
  typedef enum logic [1:0] {IDLE, RAMP, BRAKE, DEAD} state_t;
endpackage

// File: rtl/ramp_tick_gen.sv
// ramp_tick_gen: free-running divider with synchronous clear, one-cycle Tick every RAMP_DIV cycles
module ramp_tick_gen #(
  parameter int RAMP_DIV = 1000,
  parameter int CW       = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Clr,
  output logic Tick
);
  logic [CW-1:0] cnt_q, cnt_d;
  assign Tick = cnt_q == CW'(RAMP_DIV - 1);
  // wrap on tick, restart on clear so the next tick lands RAMP_DIV cycles later
  always_comb cnt_d = (Clr | Tick) ? '0 : cnt_q + 1'b1;
  // counter register
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
endmodule

// File: rtl/speed_ramp_ctrl.sv
// speed_ramp_ctrl: command-driven duty slew controller with safe brake/dead-time direction reversal
module speed_ramp_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int MAX_RATE   = MAX_RATE_DEF,
  parameter int STEP       = 10,
  parameter int RAMP_DIV   = 1000,
  parameter int DEAD_TICKS = 4,
  parameter int CW         = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       CmdValid,
  output logic       CmdReady,
  input  logic [2:0] CmdCode,
  input  logic [6:0] CmdArg,
  input  logic       EStop,
  output logic [6:0] RateSet,
  output logic       Dir,
  output logic       Busy,
  output logic       CmdErr
);
  state_t     state_q, state_d;
  logic [6:0] target_q, target_d, saved_q, saved_d, rate_q, rate_d;
  logic [7:0] dead_q, dead_d, up_sum;
  logic [6:0] set_t, up_t, dn_t, adj_t;
  logic       dir_q, dir_d, err_q, err_d, live_q, tick, accept, clr;

  assign CmdReady = live_q & ~EStop & (state_q == IDLE || state_q == RAMP);
  assign accept   = CmdValid & CmdReady;
  assign clr      = accept | (state_d != state_q);
  assign RateSet  = rate_q;
  assign Dir      = dir_q;
  assign CmdErr   = err_q;
  assign Busy     = state_q != IDLE;

  assign up_sum = {1'b0, target_q} + 8'(STEP);
  assign set_t  = (CmdArg > 7'(MAX_RATE)) ? 7'(MAX_RATE) : CmdArg;
  assign up_t   = (up_sum > 8'(MAX_RATE)) ? 7'(MAX_RATE) : up_sum[6:0];
  assign dn_t   = ({1'b0, target_q} < 8'(STEP)) ? 7'd0 : target_q - 7'(STEP);
  assign adj_t  = (CmdCode == CMD_SET) ? set_t : (CmdCode == CMD_UP) ? up_t : dn_t;

  ramp_tick_gen #(.RAMP_DIV(RAMP_DIV), .CW(CW)) u_tick (
    .Clk  (Clk),
    .Rst  (Rst),
    .Clr  (clr),
    .Tick (tick)
  );

  // next state: EStop overrides commands, commands override the tick step
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    saved_d  = saved_q;
    rate_d   = rate_q;
    dir_d    = dir_q;
    dead_d   = dead_q;
    err_d    = 1'b0;
    if (EStop) begin
      state_d  = IDLE;
      target_d = '0;
      saved_d  = '0;
      rate_d   = '0;
      dead_d   = '0;
    end else if (accept) begin
      case (CmdCode)
        CMD_NOP: ;
        CMD_SET, CMD_UP, CMD_DOWN: begin
          target_d = adj_t;
          state_d  = (adj_t != rate_q) ? RAMP : IDLE;
        end
        CMD_STOP: begin
          target_d = '0;
          rate_d   = '0;
          state_d  = IDLE;
        end
        CMD_REVERSE: begin
          saved_d  = target_q;
          target_d = '0;
          dead_d   = '0;
          state_d  = (rate_q == '0) ? DEAD : BRAKE;
        end
        default: err_d = 1'b1;
      endcase
    end else if (tick) begin
      case (state_q)
        RAMP: begin
          rate_d  = (rate_q < target_q) ? rate_q + 7'd1 : rate_q - 7'd1;
          state_d = (rate_d == target_q) ? IDLE : RAMP;
        end
        BRAKE: begin
          rate_d  = rate_q - 7'd1;
          state_d = (rate_d == '0) ? DEAD : BRAKE;
        end
        DEAD: begin
          dead_d = dead_q + 8'd1;
          if (dead_d == 8'(DEAD_TICKS)) begin
            dir_d    = ~dir_q;
            target_d = saved_q;
            saved_d  = '0;
            state_d  = (saved_q != '0) ? RAMP : IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM and registered outputs
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state_q  <= IDLE;
      target_q <= '0;
      saved_q  <= '0;
      rate_q   <= '0;
      dir_q    <= 1'b0;
      dead_q   <= '0;
      err_q    <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      saved_q  <= saved_d;
      rate_q   <= rate_d;
      dir_q    <= dir_d;
      dead_q   <= dead_d;
      err_q    <= err_d;
      live_q   <= 1'b1;
    end
endmodule

// File: tb/tb_speed_ramp_ctrl.sv
// tb_speed_ramp_ctrl: scoreboard and vector-table bench for speed_ramp_ctrl
module tb_speed_ramp_ctrl;
  import motor_ctrl_pkg::*;

  logic       Clk = 1'b0, Rst = 1'b0, CmdValid = 1'b0, EStop = 1'b0;
  logic [2:0] CmdCode = '0;
  logic [6:0] CmdArg = '0;
  logic       CmdReady, Dir, Busy, CmdErr;
  logic [6:0] RateSet;
  int n_cmp = 0, n_bad = 0;

  localparam logic [10:0] M_RATE = 11'h07F, M_DIR = 11'h080, M_RDY = 11'h100;
  localparam logic [10:0] M_BUSY = 11'h200, M_ERR = 11'h400, M_ALL = 11'h7FF;

  typedef struct {string nm; logic [10:0] exp; logic [10:0] msk;} sb_t;
  typedef struct {logic [2:0] code; logic [6:0] arg; logic [6:0] rate; logic err;} vec_t;
  sb_t  sb[$];
  vec_t tv[13];

  speed_ramp_ctrl #(.STEP(10), .RAMP_DIV(4), .DEAD_TICKS(2), .CW(4)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .CmdValid (CmdValid),
    .CmdReady (CmdReady),
    .CmdCode  (CmdCode),
    .CmdArg   (CmdArg),
    .EStop    (EStop),
    .RateSet  (RateSet),
    .Dir      (Dir),
    .Busy     (Busy),
    .CmdErr   (CmdErr)
  );

  always #5 Clk = ~Clk;

  function automatic logic [10:0] pk(logic e, logic b, logic r, logic d, int rate);
    return {e, b, r, d, 7'(rate)};
  endfunction

  task automatic push(string nm, logic [10:0] e, logic [10:0] m);
    sb.push_back('{nm, e, m});
  endtask

  task automatic pop_chk();
    sb_t s;
    logic [10:0] g;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got nothing to compare, want an entry");
      return;
    end
    s = sb.pop_front();
    g = {CmdErr, Busy, CmdReady, Dir, RateSet};
    if (((g ^ s.exp) & s.msk) != 0) begin
      n_bad++;
      $display("FAIL %s: got err/busy/rdy/dir/rate=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d (mask %h) at %0t",
               s.nm, g[10], g[9], g[8], g[7], g[6:0], s.exp[10], s.exp[9], s.exp[8], s.exp[7], s.exp[6:0], s.msk, $time);
    end
  endtask

  task automatic check(string nm, logic [10:0] e, logic [10:0] m);
    push(nm, e, m);
    pop_chk();
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic timeout(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout, want completion", nm);
  endtask

  task automatic send(logic [2:0] code, logic [6:0] arg);
    int n = 0;
    while (!CmdReady && n < 100) begin cyc(1); n++; end
    if (!CmdReady) timeout("send_ready");
    CmdValid = 1'b1;
    CmdCode  = code;
    CmdArg   = arg;
    @(posedge Clk);
    #1;
    CmdValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 1000) begin cyc(1); n++; end
    if (Busy) timeout("wait_idle");
  endtask

  task automatic wait_rate(logic [6:0] r);
    int n = 0;
    while (RateSet != r && n < 500) begin cyc(1); n++; end
    if (RateSet != r) timeout("wait_rate");
  endtask

  initial begin
    tv[0]  = '{CMD_SET,  7'd120, 7'd99, 1'b0};
    tv[1]  = '{CMD_DOWN, 7'd0,   7'd89, 1'b0};
    tv[2]  = '{CMD_DOWN, 7'd0,   7'd79, 1'b0};
    tv[3]  = '{CMD_DOWN, 7'd0,   7'd69, 1'b0};
    tv[4]  = '{CMD_SET,  7'd5,   7'd5,  1'b0};
    tv[5]  = '{CMD_DOWN, 7'd0,   7'd0,  1'b0};
    tv[6]  = '{CMD_UP,   7'd0,   7'd10, 1'b0};
    tv[7]  = '{CMD_UP,   7'd0,   7'd20, 1'b0};
    tv[8]  = '{CMD_SET,  7'd95,  7'd95, 1'b0};
    tv[9]  = '{CMD_UP,   7'd0,   7'd99, 1'b0};
    tv[10] = '{CMD_NOP,  7'd33,  7'd99, 1'b0};
    tv[11] = '{3'd6,     7'd12,  7'd99, 1'b1};
    tv[12] = '{3'd7,     7'd40,  7'd99, 1'b1};

    cyc(3);
    check("reset_state", pk(0, 0, 0, 0, 0), M_ALL);
    Rst = 1'b1;
    #1;
    check("ready_before_edge", pk(0, 0, 0, 0, 0), M_RDY);
    cyc(1);
    check("ready_after_edge", pk(0, 0, 1, 0, 0), M_ALL);

    for (int k = 0; k <= 20; k++)
      push("t1_ramp", pk(0, k < 20, 1, 0, (k / 4 > 5) ? 5 : k / 4), M_ALL);
    send(CMD_SET, 7'd5);
    for (int k = 0; k <= 20; k++) begin pop_chk(); cyc(1); end

    send(CMD_SET, 7'd3);
    wait_idle();
    check("t3_pre", pk(0, 0, 1, 0, 3), M_ALL);
    for (int k = 0; k <= 32; k++) begin
      int r;
      r = k < 4 ? 3 : k < 8 ? 2 : k < 12 ? 1 : k < 24 ? 0 : k < 28 ? 1 : k < 32 ? 2 : 3;
      push("t3_reverse", pk(0, k < 32, k >= 20, k >= 20, r), M_ALL);
    end
    send(CMD_REVERSE, 7'd0);
    for (int k = 0; k <= 32; k++) begin pop_chk(); cyc(1); end

    send(CMD_SET, 7'd60);
    wait_rate(7'd40);
    check("t4_mid_ramp", pk(0, 1, 1, 1, 40), M_ALL);
    send(CMD_STOP, 7'd0);
    check("t4_stop", pk(0, 0, 1, 1, 0), M_ALL);

    send(CMD_SET, 7'd2);
    wait_idle();
    check("t5_pre", pk(0, 0, 1, 1, 2), M_ALL);
    send(CMD_REVERSE, 7'd0);
    cyc(10);
    check("t5_in_dead", pk(0, 1, 0, 1, 0), M_ALL);
    EStop = 1'b1;
    #1;
    check("t5_estop_ready", pk(0, 0, 0, 0, 0), M_RDY);
    cyc(1);
    check("t5_estop_idle", pk(0, 0, 0, 1, 0), M_ALL);
    cyc(12);
    check("t5_estop_hold", pk(0, 0, 0, 1, 0), M_ALL);
    EStop = 1'b0;
    #1;
    check("t5_release_ready", pk(0, 0, 1, 0, 0), M_RDY);
    cyc(20);
    check("t5_saved_lost", pk(0, 0, 1, 1, 0), M_ALL);
    send(CMD_SET, 7'd2);
    cyc(4);
    check("t5_ramp_first", pk(0, 1, 1, 1, 1), M_ALL);
    wait_idle();
    check("t5_ramp_done", pk(0, 0, 1, 1, 2), M_ALL);

    for (int i = 0; i < 13; i++) begin
      send(tv[i].code, tv[i].arg);
      check($sformatf("tv%0d_err", i), pk(tv[i].err, 0, 0, 0, 0), M_ERR);
      wait_idle();
      check($sformatf("tv%0d_rate", i), pk(0, 0, 0, 0, tv[i].rate), M_RATE | M_BUSY);
    end

    send(3'd7, 7'd0);
    check("t6_err_on", pk(1, 0, 1, 1, 99), M_ALL);
    cyc(1);
    check("t6_err_off", pk(0, 0, 1, 1, 99), M_ALL);
    send(CMD_SET, 7'd50);
    cyc(10);
    check("t6_mid_ramp", pk(0, 1, 1, 1, 97), M_ALL);
    #3 Rst = 1'b0;
    #1;
    check("t6_async_reset", pk(0, 0, 0, 0, 0), M_ALL | M_DIR);
    #20 Rst = 1'b1;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/speed_ramp_ctrl.md
Name: speed_ramp_ctrl

Overview:
Upstream stage of the motor PWM generator. Accepts decoded remote-control commands over a valid/ready handshake and holds a target duty. It produces the 7-bit duty value (0..MAX_RATE) for the PWM RateSet input, slewing one count per ramp tick toward the target. Direction reversals are sequenced safely: ramp to zero, wait a dead time, flip Dir, then ramp back up.

Parameters:
MAX_RATE, 99, saturation ceiling for target and duty; must match PWM period (Cnt wraps at 99).
STEP, 10, increment/decrement applied by UP/DOWN commands.
RAMP_DIV, 1000, Clk cycles per ramp tick; must be >= 2.
DEAD_TICKS, 4, ramp ticks held at zero duty before Dir flips.
CW, 16, tick-counter width; must satisfy 2^CW >= RAMP_DIV.

Ports:
Clk  in  1  clock
Rst  in  1  asynchronous, active-low reset
CmdValid  in  1  command present
CmdReady  out  1  block can accept a command this cycle
CmdCode  in  3  0 NOP, 1 SET, 2 UP, 3 DOWN, 4 STOP, 5 REVERSE, 6/7 illegal
CmdArg  in  7  SET operand
EStop  in  1  level emergency stop, synchronous to Clk
RateSet  out  7  duty to PWM, registered
Dir  out  1  motor direction, registered
Busy  out  1  high when not in IDLE
CmdErr  out  1  one-cycle pulse on an accepted illegal code

Behaviour:
- Reset: RateSet=0, Dir=0, CmdReady=0, Busy=0, CmdErr=0, target=0, state=IDLE, tick counter=0. CmdReady rises on the first Clk edge after Rst deasserts.
- Accept = CmdValid & CmdReady, sampled on a rising Clk edge. The command takes effect on target in the same edge. Registered outputs reflect it the following cycle.
- CmdReady = 1 in IDLE and RAMP. CmdReady = 0 in BRAKE, DEAD, and any cycle where EStop is high.
- Target update, all saturating:
  - SET: target = min(CmdArg, MAX_RATE).
  - UP: target = min(target+STEP, MAX_RATE).
  - DOWN: target = max(target-STEP, 0). Compute in 8 bits; no wrap.
  - STOP: target = 0 and RateSet = 0 on the next edge, with no ramp. State goes to IDLE.
  - NOP: no effect.
  - Illegal code: no effect; CmdErr pulses for 1 cycle.
- Tick counter: cleared on every accept and every state transition; otherwise increments. Tick is asserted when count == RAMP_DIV-1, and the counter then wraps to 0. The first ramp step therefore occurs exactly RAMP_DIV cycles after acceptance.
- States:
  - IDLE: RateSet == target.
    - Target change moves to RAMP.
    - REVERSE with RateSet==0 moves to DEAD.
    - REVERSE with RateSet>0 saves target and moves to BRAKE.
  - RAMP: each tick moves RateSet one count toward target. Returns to IDLE on the edge where RateSet reaches target. REVERSE in RAMP behaves as in IDLE.
  - BRAKE: target forced to 0. Each tick decrements RateSet. On reaching 0, moves to DEAD.
  - DEAD: counts DEAD_TICKS ticks with RateSet=0. Then toggles Dir, restores the saved target, and moves to RAMP. If the saved target is 0, it moves to IDLE instead.
- EStop high:
  - Next edge sets RateSet=0 and target=0.
  - Saved target is discarded, and any pending reversal is cancelled with Dir unchanged.
  - State = IDLE; commands are not accepted.
  - On release, normal operation resumes from IDLE with target 0.
- Precedence on the same edge: Rst > EStop > accepted command > tick step.
- A command accepted on a tick edge updates target; the step on that edge is not applied because the tick counter clears.
- RateSet never exceeds MAX_RATE. RateSet changes by at most 1 per tick, except for STOP and EStop.
- Busy = (state != IDLE).

Decomposition:
- Package motor_ctrl_pkg holds:
  - command code constants (CMD_NOP..CMD_REVERSE);
  - state enum (IDLE, RAMP, BRAKE, DEAD);
  - default MAX_RATE.
- One sub-module, ramp_tick_gen(RAMP_DIV, CW): a counter with synchronous clear, producing a one-cycle tick. It uses the same Rst/Clk.

Test Plan:
Test parameters: RAMP_DIV=4, STEP=10, DEAD_TICKS=2.
1. Reset release, then SET 5 -> RateSet steps 1,2,3,4,5 at 4-cycle spacing; first step 4 cycles after accept; Busy falls with RateSet=5.
2. SET 120 -> target saturates to 99; 3×DOWN from 99 -> target 69; DOWN from 5 -> target 0, no wrap.
3. RateSet=3, REVERSE -> CmdReady low; RateSet goes 2,1,0; Dir holds 0 for 2 ticks, then Dir=1; RateSet ramps back to 3; CmdReady high again in RAMP.
4. RateSet=40 mid-ramp, STOP -> RateSet=0 on the next edge, state IDLE, Busy=0.
5. EStop during DEAD -> RateSet stays 0, Dir not toggled, saved target lost; after release, SET 2 ramps from 0 in the original direction.
6. CmdCode=7 accepted -> CmdErr high exactly 1 cycle, target unchanged. Assert Rst low mid-ramp -> all outputs return to reset values immediately (asynchronously).
